matrix_4x4_serialize: RTL and testbench

Downstream output stage of the 4x4 fixed-point matrix multiplier. Accepts a complete 4x4 result matrix (four column vectors) in one valid/ready transfer and emits it as a stream of one W-bit element per cycle, with row/column tags and an end-of-matrix marker. A two-entry ping-pong buffer lets the multiplier hand over the next matrix while the current one drains, so back-to-back matrices stream with no bubble.

---
 rtl/matrix_4x4_pkg.sv | 27 ++
 rtl/matrix_4x4_pingpong.sv | 61 ++++++
 rtl/matrix_4x4_serialize.sv | 63 ++++++
 tb/tb_matrix_4x4_serialize.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_4x4_pkg.sv
// Shared types and constants for the 4x4 fixed-point matrix datapath.
// MATRIX_4X4_ROW_MAJOR_EN selects row-major element emit order.
package matrix_4x4_pkg;

    localparam int MAT_W     = 12;
    localparam int MAT_N     = 4;
    localparam int MAT_ELEMS = 16;

    typedef logic [MAT_N-1:0][MAT_W-1:0] col_vec_t;
    typedef logic [1:0]                  idx_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // Maps stream position k to bank address {col,row}
    function automatic logic [3:0] bank_addr(input logic [3:0] k);
`ifdef MATRIX_4X4_ROW_MAJOR_EN
        return {k[1:0], k[3:2]};
`else
        return k;
`endif
    endfunction

endpackage

// File: rtl/matrix_4x4_pingpong.sv
// Two-bank matrix buffer: whole-matrix write, whole-matrix release.
// Bank element address is {col,row}.
module matrix_4x4_pingpong
    import matrix_4x4_pkg::*;
#(
    parameter int W = MAT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_valid,
    input  logic [MAT_N-1:0][W-1:0]      i_c0,
    input  logic [MAT_N-1:0][W-1:0]      i_c1,
    input  logic [MAT_N-1:0][W-1:0]      i_c2,
    input  logic [MAT_N-1:0][W-1:0]      i_c3,
    output logic                         o_wr_ready,
    input  logic                         i_rd_done,
    output logic                         o_rd_valid,
    output logic [MAT_ELEMS-1:0][W-1:0]  o_rd_bank
);

    occ_t                         r_count;
    logic                         r_wr_ptr;
    logic                         r_rd_ptr;
    logic [MAT_ELEMS-1:0][W-1:0]  r_bank [2];

    logic                         w_push;
    logic                         w_pop;
    logic [MAT_ELEMS-1:0][W-1:0]  w_wr_flat;

    assign o_wr_ready = (r_count != OCC_FULL);
    assign o_rd_valid = (r_count != OCC_EMPTY);
    assign w_push     = i_wr_valid && o_wr_ready;
    assign w_pop      = i_rd_done && o_rd_valid;
    assign w_wr_flat  = {i_c3, i_c2, i_c1, i_c0};
    assign o_rd_bank  = r_bank[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= OCC_EMPTY;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= (r_count == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
                2'b01:   r_count <= (r_count == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
                default: r_count <= r_count;
            endcase
        end
    end

    // Bank contents need no reset; occupancy gates their visibility
    always_ff @(posedge clk) begin
        if (w_push)
            r_bank[r_wr_ptr] <= w_wr_flat;
    end

endmodule

// File: rtl/matrix_4x4_serialize.sv
// Serializes buffered 4x4 result matrices into a tagged element stream.
// MATRIX_4X4_ROW_MAJOR_EN switches emit order from column- to row-major.
module matrix_4x4_serialize
    import matrix_4x4_pkg::*;
#(
    parameter int W = MAT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [MAT_N-1:0][W-1:0]  cC1,
    input  logic [MAT_N-1:0][W-1:0]  cC2,
    input  logic [MAT_N-1:0][W-1:0]  cC3,
    input  logic [MAT_N-1:0][W-1:0]  cC4,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [W-1:0]             data_out,
    output idx_t                     row_out,
    output idx_t                     col_out,
    output logic                     last_out
);

    logic [3:0]                   r_elem;
    logic                         w_fire;
    logic                         w_last;
    logic                         w_rd_done;
    logic [3:0]                   w_addr;
    logic [MAT_ELEMS-1:0][W-1:0]  w_bank;

    matrix_4x4_pingpong #(.W(W)) u_pingpong (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_valid (valid_in),
        .i_c0       (cC1),
        .i_c1       (cC2),
        .i_c2       (cC3),
        .i_c3       (cC4),
        .o_wr_ready (ready_out),
        .i_rd_done  (w_rd_done),
        .o_rd_valid (valid_out),
        .o_rd_bank  (w_bank)
    );

    assign w_fire    = valid_out && ready_in;
    assign w_last    = (r_elem == 4'(MAT_ELEMS - 1));
    assign w_rd_done = w_fire && w_last;

    // Counter wraps 15 -> 0 as the matrix is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_elem <= 4'd0;
        else if (w_fire)
            r_elem <= r_elem + 4'd1;
    end

    assign w_addr   = bank_addr(r_elem);
    assign data_out = w_bank[w_addr];
    assign row_out  = w_addr[1:0];
    assign col_out  = w_addr[3:2];
    assign last_out = valid_out && w_last;

endmodule

// File: tb/tb_matrix_4x4_serialize.sv
// Scoreboard bench for matrix_4x4_serialize; expected elements queued on
// matrix acceptance and compared as the stream drains.
module tb_matrix_4x4_serialize;
    import matrix_4x4_pkg::*;

    localparam int W = MAT_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_in = 1'b0;
    logic               ready_in = 1'b0;
    logic [3:0][W-1:0]  cC1, cC2, cC3, cC4;
    logic               ready_out;
    logic               valid_out;
    logic [W-1:0]       data_out;
    logic [1:0]         row_out;
    logic [1:0]         col_out;
    logic               last_out;

    int          n_pass = 0;
    int          n_total = 0;
    int          occ = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    matrix_4x4_serialize dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .cC1       (cC1),
        .cC2       (cC2),
        .cC3       (cC3),
        .cC4       (cC4),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .row_out   (row_out),
        .col_out   (col_out),
        .last_out  (last_out)
    );

    function automatic logic [W-1:0] mval(input int id, input int r, input int c);
        if (id == 255)
            return 12'hFFF;
        return W'((id << 8) | (c << 4) | r);
    endfunction

    task automatic load(input int id);
        for (int r = 0; r < 4; r++) begin
            cC1[r] = mval(id, r, 0);
            cC2[r] = mval(id, r, 1);
            cC3[r] = mval(id, r, 2);
            cC4[r] = mval(id, r, 3);
        end
    endtask

    task automatic push_exp(input int id);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] kk;
            int r, c;
            kk = 4'(k);
`ifdef MATRIX_4X4_ROW_MAJOR_EN
            r = int'(kk[3:2]);
            c = int'(kk[1:0]);
`else
            r = int'(kk[1:0]);
            c = int'(kk[3:2]);
`endif
            exp_q.push_back({mval(id, r, c), 2'(r), 2'(c), (k == 15)});
        end
    endtask

    // Drive inputs at negedge; report handshakes taken at the next posedge
    task automatic step(input bit vin, input bit rin, input int id,
                        output bit acc, output bit fire);
        @(negedge clk);
        load(id);
        valid_in = vin;
        ready_in = rin;
        acc  = vin && (ready_out === 1'b1);
        fire = rin && (valid_out === 1'b1);
        if (acc)
            push_exp(id);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if ({valid_out, ready_out} !== 2'b01)
            $display("FAIL reset_held v/r got=%b exp=01", {valid_out, ready_out});
        else
            n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (valid_out !== 1'b0)
            $display("FAIL reset_valid got=%b exp=0", valid_out);
        else
            n_pass++;
        n_total++;
        if (ready_out !== 1'b1)
            $display("FAIL reset_ready got=%b exp=1", ready_out);
        else
            n_pass++;
        n_total++;
        if ({last_out, row_out, col_out} !== 5'b0)
            $display("FAIL reset_tags got=%b exp=00000", {last_out, row_out, col_out});
        else
            n_pass++;
    endtask

    task automatic test_single();
        bit acc, fire;
        logic [16:0] e;
        int got = 0;
        occ = 0;
        step(1'b1, 1'b1, 0, acc, fire);
        n_total++;
        if (acc !== 1'b1)
            $display("FAIL single_accept got=%b exp=1", acc);
        else
            n_pass++;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            step(1'b0, 1'b1, 0, acc, fire);
            if (cyc == 0) begin
                n_total++;
                if (valid_out !== 1'b1)
                    $display("FAIL single_latency got=%b exp=1", valid_out);
                else
                    n_pass++;
            end
            if (fire) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL single_extra got=%h exp=none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({data_out, row_out, col_out, last_out} !== e)
                        $display("FAIL single_elem got=%h exp=%h",
                                 {data_out, row_out, col_out, last_out}, e);
                    else
                        n_pass++;
                end
                got++;
            end
        end
        step(1'b0, 1'b1, 0, acc, fire);
        n_total++;
        if ({valid_out, ready_out, last_out} !== 3'b010)
            $display("FAIL single_after v/r/l got=%b exp=010",
                     {valid_out, ready_out, last_out});
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        bit acc, fire, started;
        logic [16:0] e;
        int got = 0;
        int sent = 0;
        started = 1'b0;
        occ = 0;
        for (int cyc = 0; cyc < 150 && got < 48; cyc++) begin
            step(sent < 3, 1'b1, 1 + sent, acc, fire);
            n_total++;
            if (ready_out !== (occ != 2))
                $display("FAIL b2b_ready got=%b exp=%b", ready_out, (occ != 2));
            else
                n_pass++;
            if (started) begin
                n_total++;
                if (valid_out !== 1'b1)
                    $display("FAIL b2b_gap got=%b exp=1 at elem %0d", valid_out, got);
                else
                    n_pass++;
            end
            if (valid_out === 1'b1)
                started = 1'b1;
            if (fire) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra got=%h exp=none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({data_out, row_out, col_out, last_out} !== e)
                        $display("FAIL b2b_elem got=%h exp=%h",
                                 {data_out, row_out, col_out, last_out}, e);
                    else
                        n_pass++;
                    if (e[0])
                        occ--;
                end
                got++;
            end
            if (acc) begin
                sent++;
                occ++;
            end
        end
        n_total++;
        if (got !== 48)
            $display("FAIL b2b_count got=%0d exp=48", got);
        else
            n_pass++;
    endtask

    task automatic test_stall();
        bit acc, fire, rin, prev_stall;
        logic [16:0] e;
        logic [17:0] prev_out;
        int got = 0;
        int sent = 0;
        prev_stall = 1'b0;
        prev_out = '0;
        for (int cyc = 0; cyc < 200 && got < 32; cyc++) begin
            rin = (cyc % 4 == 0) || (cyc % 4 == 3);
            step(sent < 2, rin, 4 + sent, acc, fire);
            if (prev_stall) begin
                n_total++;
                if ({valid_out, data_out, row_out, col_out, last_out} !== prev_out)
                    $display("FAIL stall_hold got=%h exp=%h",
                             {valid_out, data_out, row_out, col_out, last_out}, prev_out);
                else
                    n_pass++;
            end
            prev_stall = (valid_out === 1'b1) && !rin;
            prev_out = {valid_out, data_out, row_out, col_out, last_out};
            if (fire) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stall_extra got=%h exp=none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({data_out, row_out, col_out, last_out} !== e)
                        $display("FAIL stall_elem got=%h exp=%h",
                                 {data_out, row_out, col_out, last_out}, e);
                    else
                        n_pass++;
                end
                got++;
            end
            if (acc)
                sent++;
        end
        n_total++;
        if (got !== 32 || exp_q.size() != 0)
            $display("FAIL stall_count got=%0d exp=32", got);
        else
            n_pass++;
    endtask

    task automatic test_full();
        bit acc, fire;
        logic [16:0] e;
        int got = 0;
        int sent = 0;
        int ids[3] = '{6, 7, 255};
        occ = 0;
        for (int cyc = 0; cyc < 200 && got < 48; cyc++) begin
            step(sent < 3, cyc >= 6, ids[sent < 3 ? sent : 2], acc, fire);
            n_total++;
            if (ready_out !== (occ != 2))
                $display("FAIL full_ready got=%b exp=%b", ready_out, (occ != 2));
            else
                n_pass++;
            if (fire) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL full_extra got=%h exp=none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({data_out, row_out, col_out, last_out} !== e)
                        $display("FAIL full_elem got=%h exp=%h",
                                 {data_out, row_out, col_out, last_out}, e);
                    else
                        n_pass++;
                    if (e[0])
                        occ--;
                end
                got++;
            end
            if (acc) begin
                sent++;
                occ++;
            end
        end
        n_total++;
        if (got !== 48)
            $display("FAIL full_count got=%0d exp=48", got);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid();
        bit acc, fire;
        logic [16:0] e;
        int got = 0;
        step(1'b1, 1'b1, 8, acc, fire);
        for (int cyc = 0; cyc < 40 && got < 7; cyc++) begin
            step(1'b0, 1'b1, 8, acc, fire);
            if (fire) begin
                void'(exp_q.pop_front());
                got++;
            end
        end
        @(posedge clk);
        #2;
        n_total++;
        if (valid_out !== 1'b1)
            $display("FAIL rstmid_pre got=%b exp=1", valid_out);
        else
            n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({valid_out, ready_out, row_out, col_out, last_out} !== 7'b0100000)
            $display("FAIL rstmid_async got=%b exp=0100000",
                     {valid_out, ready_out, row_out, col_out, last_out});
        else
            n_pass++;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 9, acc, fire);
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            step(1'b0, 1'b1, 9, acc, fire);
            if (fire) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rstmid_extra got=%h exp=none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({data_out, row_out, col_out, last_out} !== e)
                        $display("FAIL rstmid_elem got=%h exp=%h",
                                 {data_out, row_out, col_out, last_out}, e);
                    else
                        n_pass++;
                end
                got++;
            end
        end
        n_total++;
        if (got !== 16)
            $display("FAIL rstmid_count got=%0d exp=16", got);
        else
            n_pass++;
    endtask

    initial begin
        load(0);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
